// File: rtl/ccir656_pkg.sv
// Shared BT.656 definitions for the ccir656 transmitter and receiver:
// TRS preamble bytes, the eight protected XY codes, receiver FSM states, and XY helpers.
package ccir656_pkg;

    localparam logic [7:0] TRS_FF           = 8'hFF;
    localparam logic [7:0] TRS_00           = 8'h00;
    localparam int         ACTIVE_BYTES_DEF = 1440;

    // Index is {F,V,H}; entry 0 is 8'h80 (F=0 V=0 H=0).
    localparam logic [7:0][7:0] XY_CODES = {
        8'hF1, 8'hEC, 8'hDA, 8'hC7, 8'hB6, 8'hAB, 8'h9D, 8'h80
    };

    typedef enum logic [2:0] {
        SEARCH   = 3'd0,
        GOT_FF   = 3'd1,
        GOT_00   = 3'd2,
        GOT_0000 = 3'd3,
        ACTIVE   = 3'd4
    } rx_state_e;

    function automatic logic [7:0] xy_encode(input logic f, input logic v, input logic h);
        return {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h};
    endfunction

    function automatic logic [3:0] hamming8(input logic [7:0] a, input logic [7:0] b);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, a[i] ^ b[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/ccir656_xy_decode.sv
// Combinational XY status-word decoder: recovers F/V/H and reports validity.
// With CCIR656_RX_ECC_EN defined, single-bit errors are corrected and flagged.
module ccir656_xy_decode
    import ccir656_pkg::*;
(
    input  logic [7:0] xy,
    output logic       f,
    output logic       v,
    output logic       h,
`ifdef CCIR656_RX_ECC_EN
    output logic       corrected,
`endif
    output logic       valid
);

`ifdef CCIR656_RX_ECC_EN
    logic [7:0] code_s;
    logic       near_s;
    logic       exact_s;
    logic [3:0] dist_s;

    // Codes are at least distance 4 apart, so at most one lies within distance 1.
    always_comb begin
        code_s  = xy;
        near_s  = 1'b0;
        exact_s = 1'b0;
        dist_s  = 4'd0;
        for (int i = 0; i < 8; i++) begin
            dist_s  = hamming8(xy, XY_CODES[i]);
            code_s  = (dist_s <= 4'd1) ? XY_CODES[i] : code_s;
            near_s  = near_s | (dist_s <= 4'd1);
            exact_s = exact_s | (dist_s == 4'd0);
        end
        f         = code_s[6];
        v         = code_s[5];
        h         = code_s[4];
        valid     = near_s;
        corrected = near_s & ~exact_s;
    end
`else
    // Exact match only: the word must equal its own re-encoding.
    always_comb begin
        f     = xy[6];
        v     = xy[5];
        h     = xy[4];
        valid = (xy == xy_encode(xy[6], xy[5], xy[4]));
    end
`endif

endmodule

// File: rtl/ccir656_rx.sv
// BT.656 byte-stream receiver: TRS detection, XY decode, active-video extraction.
// Optional macro CCIR656_RX_ECC_EN adds single-bit XY correction and the xy_corr port.
module ccir656_rx
    import ccir656_pkg::*;
#(
    parameter int ACTIVE_BYTES = ACTIVE_BYTES_DEF,
    parameter int LINE_W       = 10
)
(
    input  logic              clk27M,
    input  logic              rst,
    input  logic [7:0]        data,
    output logic [7:0]        pix_data,
    output logic              pix_valid,
    output logic              sav,
    output logic              eav,
    output logic              field,
    output logic              vblank,
    output logic [LINE_W-1:0] line_num,
    output logic              xy_err,
    output logic              len_err,
`ifdef CCIR656_RX_ECC_EN
    output logic              xy_corr,
`endif
    output logic              locked
);

    localparam int                CNT_W    = $clog2(ACTIVE_BYTES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(ACTIVE_BYTES - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(ACTIVE_BYTES);
    localparam logic [LINE_W-1:0] LINE_MAX = '1;

    rx_state_e         state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [7:0]        pix_data_r;
    logic              pix_valid_r;
    logic              sav_r;
    logic              eav_r;
    logic              field_r;
    logic              vblank_r;
    logic [LINE_W-1:0] line_num_r;
    logic              xy_err_r;
    logic              len_err_r;
    logic              locked_r;
    logic              xy_f_s;
    logic              xy_v_s;
    logic              xy_h_s;
    logic              xy_valid_s;
`ifdef CCIR656_RX_ECC_EN
    logic              xy_corr_s;
    logic              xy_corr_r;
`endif

    ccir656_xy_decode u_xy_decode (
        .xy        (data),
        .f         (xy_f_s),
        .v         (xy_v_s),
        .h         (xy_h_s),
`ifdef CCIR656_RX_ECC_EN
        .corrected (xy_corr_s),
`endif
        .valid     (xy_valid_s)
    );

    // Preamble/active-video FSM with all status outputs registered.
    always_ff @(posedge clk27M) begin
        if (rst) begin
            state_r     <= SEARCH;
            cnt_r       <= '0;
            pix_data_r  <= 8'h00;
            pix_valid_r <= 1'b0;
            sav_r       <= 1'b0;
            eav_r       <= 1'b0;
            field_r     <= 1'b0;
            vblank_r    <= 1'b0;
            line_num_r  <= '0;
            xy_err_r    <= 1'b0;
            len_err_r   <= 1'b0;
            locked_r    <= 1'b0;
`ifdef CCIR656_RX_ECC_EN
            xy_corr_r   <= 1'b0;
`endif
        end else begin
            pix_valid_r <= 1'b0;
            sav_r       <= 1'b0;
            eav_r       <= 1'b0;
            xy_err_r    <= 1'b0;
            len_err_r   <= 1'b0;
`ifdef CCIR656_RX_ECC_EN
            xy_corr_r   <= 1'b0;
`endif
            case (state_r)
                SEARCH: begin
                    state_r <= (data == TRS_FF) ? GOT_FF : SEARCH;
                end
                GOT_FF: begin
                    if (data == TRS_00)      state_r <= GOT_00;
                    else if (data == TRS_FF) state_r <= GOT_FF;
                    else                     state_r <= SEARCH;
                end
                GOT_00: begin
                    if (data == TRS_00)      state_r <= GOT_0000;
                    else if (data == TRS_FF) state_r <= GOT_FF;
                    else                     state_r <= SEARCH;
                end
                GOT_0000: begin
                    state_r <= SEARCH;
                    if (!xy_valid_s) begin
                        xy_err_r <= 1'b1;
                        locked_r <= 1'b0;
                    end else begin
                        field_r   <= xy_f_s;
                        vblank_r  <= xy_v_s;
`ifdef CCIR656_RX_ECC_EN
                        xy_corr_r <= xy_corr_s;
`endif
                        if (xy_h_s) begin
                            eav_r    <= 1'b1;
                            locked_r <= 1'b1;
                            // A field change restarts the count instead of advancing it.
                            if (xy_f_s != field_r)           line_num_r <= '0;
                            else if (line_num_r != LINE_MAX) line_num_r <= line_num_r + LINE_W'(1);
                            else                             line_num_r <= line_num_r;
                        end else begin
                            sav_r <= 1'b1;
                            if (!xy_v_s) begin
                                state_r <= ACTIVE;
                                cnt_r   <= '0;
                            end else begin
                                state_r <= SEARCH;
                            end
                        end
                    end
                end
                ACTIVE: begin
                    if (data == TRS_FF) begin
                        state_r   <= GOT_FF;
                        len_err_r <= (cnt_r < CNT_FULL);
                    end else begin
                        pix_data_r  <= data;
                        pix_valid_r <= 1'b1;
                        cnt_r       <= cnt_r + CNT_W'(1);
                        state_r     <= (cnt_r == CNT_LAST) ? SEARCH : ACTIVE;
                    end
                end
                default: begin
                    state_r <= SEARCH;
                end
            endcase
        end
    end

    assign pix_data  = pix_data_r;
    assign pix_valid = pix_valid_r;
    assign sav       = sav_r;
    assign eav       = eav_r;
    assign field     = field_r;
    assign vblank    = vblank_r;
    assign line_num  = line_num_r;
    assign xy_err    = xy_err_r;
    assign len_err   = len_err_r;
    assign locked    = locked_r;
`ifdef CCIR656_RX_ECC_EN
    assign xy_corr   = xy_corr_r;
`endif

endmodule
